nor_gate_pipe: RTL and testbench
================================

Name: nor_gate_pipe

Overview:
Parametrised, pipelined N-input bitwise logic unit. It generalises the 2-input NOR gate to N_IN operands of WIDTH bits each, with a runtime-selectable gate function. It adds a valid/ready handshake, a 2-stage register pipeline with backpressure, and a transaction counter. It is the standard registered gate primitive for datapaths that need flow control.

Parameters:
WIDTH, 8, bit width of each operand and of the result
N_IN, 2, number of operands (legal range 2..16; elaboration error outside that range)
COUNT_W, 16, width of the completed-transaction counter

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  input transaction present
in_ready  output  1  unit can accept an input this cycle
in_data  input  N_IN*WIDTH  operands, operand k at bits [k*WIDTH +: WIDTH]
in_mode  input  3  gate function for this transaction
out_valid  output  1  result present
out_ready  input  1  downstream accepts the result
out_data  output  WIDTH  result
out_mode  output  3  mode that produced out_data
txn_count  output  COUNT_W  number of results consumed since reset

Behaviour:
- One clock domain. Reset is synchronous and active-high. Clock port is clk, reset port is rst.
- Reset values: out_valid=0, out_data=0, out_mode=0, txn_count=0, internal stage-1 valid=0. in_ready is 1 in the first cycle after reset is released.
- Modes, applied bitwise across all N_IN operands:
  - 0 AND
  - 1 OR
  - 2 NAND
  - 3 NOR
  - 4 XOR (odd parity)
  - 5 XNOR
  - 6 PASS (operand 0)
  - 7 NOT (~operand 0)
- Stage 1 (S1) registers in_data and in_mode when the input handshake fires (in_valid & in_ready).
- Stage 2 (S2) computes the function from the S1 registers and registers out_data and out_mode.
- Latency: a transaction accepted at edge N appears with out_valid=1 after edge N+1, provided S2 is free.
- Throughput: 1 transaction per cycle while out_ready stays high.
- Advance rules:
  - s2_load = S1 valid & (~out_valid | out_ready)
  - in_ready = ~S1 valid | s2_load
  - in_ready depends combinationally on out_ready. This path is intended.
- Output handshake completes on out_valid & out_ready. If S2 is not reloaded in the same cycle, out_valid drops to 0.
- While out_valid=1 and out_ready=0, out_data and out_mode hold stable.
- Full condition: S1 and S2 both valid with out_ready=0. Then in_ready=0, and in_data/in_mode are ignored even if in_valid=1.
- Simultaneous events: an output consume, S1→S2 move and new input accept can all occur in the same cycle. No bubble is inserted.
- Ordering: results leave strictly in acceptance order. Nothing is dropped or duplicated except by reset.
- Input protocol: once in_valid is asserted, in_data/in_mode are not required to hold. The block samples them only on the handshake cycle.
- txn_count increments by 1 on each output handshake and wraps from 2^COUNT_W-1 to 0.
- Reset mid-operation: all in-flight transactions are discarded, valids clear, and txn_count returns to 0. Reset overrides any same-cycle handshake.
- With N_IN=2, WIDTH=1, mode=3 and out_ready tied high, out_data equals ~(a|b) of the operands accepted 2 edges earlier.

Test Plan:
1. WIDTH=8, N_IN=3, mode=3 (NOR), operands 0x01,0x02,0x04, out_ready=1 -> out_data=0xF8, out_mode=3, out_valid high exactly 2 edges after acceptance; then 0x0F,0xF0,0x00 -> 0x00.
2. All modes with operands 0xFF,0x0F,0x01 -> AND 0x01, OR 0xFF, NAND 0xFE, NOR 0x00, XOR 0xF1, XNOR 0x0E, PASS 0xFF, NOT 0x00.
3. Backpressure: out_ready=0, drive in_valid=1 with 3 distinct values -> first 2 accepted, in_ready=0 on the third, out_data stable. Raise out_ready -> all 3 emerge in order, no gaps, txn_count=3.
4. Streaming: 20 back-to-back transactions with out_ready=1 -> 1 result per cycle, in_ready never low, txn_count=20.
5. Reset mid-operation: assert rst for 1 cycle while S1 and S2 are valid with in_valid=1 -> next cycle out_valid=0, txn_count=0, in_ready=1; the input offered during the reset cycle is never output.
6. COUNT_W=4: complete 17 transactions -> txn_count wraps to 0 after the 16th and reads 1 after the 17th.

Source files
------------

// File: rtl/nor_gate_pipe.sv
// Pipelined N-input bitwise gate with runtime-selectable function.
// Two register stages with valid/ready flow control and a completed-transaction counter.
module nor_gate_pipe #(
    parameter int WIDTH   = 8,
    parameter int N_IN    = 2,
    parameter int COUNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N_IN*WIDTH-1:0]  in_data,
    input  logic [2:0]             in_mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [2:0]             out_mode,
    output logic [COUNT_W-1:0]     txn_count
);

    generate
        if (N_IN < 2 || N_IN > 16) begin : g_bad_n_in
            $error("nor_gate_pipe: N_IN must be in range 2..16");
        end
    endgenerate

    typedef enum logic [2:0] {
        MODE_AND  = 3'd0,
        MODE_OR   = 3'd1,
        MODE_NAND = 3'd2,
        MODE_NOR  = 3'd3,
        MODE_XOR  = 3'd4,
        MODE_XNOR = 3'd5,
        MODE_PASS = 3'd6,
        MODE_NOT  = 3'd7
    } mode_e;

    logic                  s1_valid;
    logic [N_IN*WIDTH-1:0] s1_data;
    logic [2:0]            s1_mode;

    logic                  s2_load;
    logic                  in_fire;
    logic [WIDTH-1:0]      red_and, red_or, red_xor, op0, result;

    // in_ready deliberately sees out_ready combinationally so a full pipe
    // can still accept a new operand in the cycle its result drains.
    assign s2_load  = s1_valid & (~out_valid | out_ready);
    assign in_ready = ~s1_valid | s2_load;
    assign in_fire  = in_valid & in_ready;

    always_comb begin
        red_and = '1;
        red_or  = '0;
        red_xor = '0;
        for (int unsigned k = 0; k < N_IN; k++) begin
            red_and = red_and & s1_data[k*WIDTH +: WIDTH];
            red_or  = red_or  | s1_data[k*WIDTH +: WIDTH];
            red_xor = red_xor ^ s1_data[k*WIDTH +: WIDTH];
        end
        op0 = s1_data[WIDTH-1:0];
        case (mode_e'(s1_mode))
            MODE_AND:  result = red_and;
            MODE_OR:   result = red_or;
            MODE_NAND: result = ~red_and;
            MODE_NOR:  result = ~red_or;
            MODE_XOR:  result = red_xor;
            MODE_XNOR: result = ~red_xor;
            MODE_PASS: result = op0;
            MODE_NOT:  result = ~op0;
            default:   result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_data   <= '0;
            s1_mode   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_mode  <= '0;
            txn_count <= '0;
        end else begin
            if (in_fire) begin
                s1_data  <= in_data;
                s1_mode  <= in_mode;
                s1_valid <= 1'b1;
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end

            if (s2_load) begin
                out_valid <= 1'b1;
                out_data  <= result;
                out_mode  <= s1_mode;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (out_valid && out_ready)
                txn_count <= txn_count + COUNT_W'(1);
        end
    end

endmodule

// File: tb/tb_nor_gate_pipe.sv
// Randomized and directed bench for nor_gate_pipe (WIDTH=8, N_IN=3, COUNT_W=4)
// against a queue-based transaction model with per-bit ones-count gate reference.
module tb_nor_gate_pipe;

    localparam int WIDTH   = 8;
    localparam int N_IN    = 3;
    localparam int COUNT_W = 4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic [N_IN*WIDTH-1:0] in_data = '0;
    logic [2:0]            in_mode = '0;
    logic                  out_valid;
    logic                  out_ready = 1'b0;
    logic [WIDTH-1:0]      out_data;
    logic [2:0]            out_mode;
    logic [COUNT_W-1:0]    txn_count;

    nor_gate_pipe #(.WIDTH(WIDTH), .N_IN(N_IN), .COUNT_W(COUNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_mode(out_mode),
        .txn_count(txn_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] d;
        logic [2:0]       m;
        bit               vis;
    } item_t;

    item_t            q[$];
    int unsigned      cnt = 0;
    logic [WIDTH-1:0] shown_d = '0;
    logic [2:0]       shown_m = '0;
    int unsigned      n_checks = 0;
    int unsigned      n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Each result bit decided by how many operands have a 1 in that position.
    function automatic logic [WIDTH-1:0] ref_gate(input logic [N_IN*WIDTH-1:0] d, input logic [2:0] m);
        logic [WIDTH-1:0] r;
        int ones;
        logic b0;
        r = '0;
        for (int b = 0; b < WIDTH; b++) begin
            ones = 0;
            for (int k = 0; k < N_IN; k++) ones += int'(d[k*WIDTH + b]);
            b0 = d[b];
            case (m)
                3'd0: r[b] = (ones == N_IN);
                3'd1: r[b] = (ones > 0);
                3'd2: r[b] = !(ones == N_IN);
                3'd3: r[b] = (ones == 0);
                3'd4: r[b] = (ones % 2 == 1);
                3'd5: r[b] = (ones % 2 == 0);
                3'd6: r[b] = b0;
                default: r[b] = !b0;
            endcase
        end
        return r;
    endfunction

    task automatic cycle(input bit v, input logic [N_IN*WIDTH-1:0] d, input logic [2:0] m,
                         input bit ordy, input bit r);
        bit exp_ov, exp_ir;
        @(negedge clk);
        exp_ov = (q.size() > 0) && q[0].vis;
        check("out_valid", 32'(out_valid), 32'(exp_ov));
        check("out_data", 32'(out_data), 32'(shown_d));
        check("out_mode", 32'(out_mode), 32'(shown_m));
        check("txn_count", 32'(txn_count), cnt);
        in_valid  = v;
        in_data   = d;
        in_mode   = m;
        out_ready = ordy;
        rst       = r;
        #1;
        // Two-deep pipe: only refuses when both slots hold data and nothing drains.
        exp_ir = !(q.size() == 2 && !ordy);
        check("in_ready", 32'(in_ready), 32'(exp_ir));
        @(posedge clk);
        if (r) begin
            q.delete();
            cnt = 0;
            shown_d = '0;
            shown_m = '0;
        end else begin
            if (exp_ov && ordy) begin
                void'(q.pop_front());
                cnt = (cnt + 1) % (1 << COUNT_W);
            end
            if (q.size() > 0 && !q[0].vis) begin
                q[0].vis = 1'b1;
                shown_d = q[0].d;
                shown_m = q[0].m;
            end
            if (v && exp_ir) q.push_back('{ref_gate(d, m), m, 1'b0});
        end
    endtask

    task automatic idle(input int n, input bit ordy);
        for (int i = 0; i < n; i++) cycle(1'b0, 24'h0, 3'd0, ordy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N_IN*WIDTH-1:0] rd;
        repeat (2) @(posedge clk);

        // NOR with single-bit operands, then complementary nibbles
        cycle(1'b1, {8'h04, 8'h02, 8'h01}, 3'd3, 1'b1, 1'b0);
        cycle(1'b1, {8'h00, 8'hF0, 8'h0F}, 3'd3, 1'b1, 1'b0);
        idle(3, 1'b1);

        // every mode on operands 0xFF,0x0F,0x01
        for (int md = 0; md < 8; md++) cycle(1'b1, {8'h01, 8'h0F, 8'hFF}, 3'(md), 1'b1, 1'b0);
        idle(3, 1'b1);

        // backpressure: third offer refused until out_ready rises
        cycle(1'b1, {8'h11, 8'h22, 8'h33}, 3'd1, 1'b0, 1'b0);
        cycle(1'b1, {8'h44, 8'h55, 8'h66}, 3'd4, 1'b0, 1'b0);
        cycle(1'b1, {8'h77, 8'h88, 8'h99}, 3'd6, 1'b0, 1'b0);
        cycle(1'b1, {8'h77, 8'h88, 8'h99}, 3'd6, 1'b0, 1'b0);
        cycle(1'b1, {8'h77, 8'h88, 8'h99}, 3'd6, 1'b1, 1'b0);
        idle(4, 1'b1);

        // back-to-back streaming, long enough to wrap the 4-bit counter
        for (int i = 0; i < 20; i++) cycle(1'b1, 24'($urandom), 3'($urandom), 1'b1, 1'b0);
        idle(3, 1'b1);

        // reset with both stages full and an input offered
        cycle(1'b1, {8'hA5, 8'h5A, 8'hC3}, 3'd0, 1'b0, 1'b0);
        cycle(1'b1, {8'h3C, 8'h96, 8'h69}, 3'd5, 1'b0, 1'b0);
        cycle(1'b1, {8'hDE, 8'hAD, 8'hBE}, 3'd7, 1'b0, 1'b1);
        idle(4, 1'b1);

        // exactly 17 completions from zero
        for (int i = 0; i < 17; i++) cycle(1'b1, 24'($urandom), 3'($urandom), 1'b1, 1'b0);
        idle(3, 1'b1);

        // random traffic with occasional reset
        for (int i = 0; i < 600; i++) begin
            rd = 24'($urandom);
            cycle($urandom_range(0, 3) != 0, rd, 3'($urandom), $urandom_range(0, 2) != 0,
                  $urandom_range(0, 99) == 0);
        end
        idle(4, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
